// File: rtl/iis_xcvr_param.sv
// iis_xcvr_param: I2S / left-justified master transceiver with bclk/lrclk generation,
// stereo TX serialiser behind a one-pair holding register and stereo RX deserialiser.
module iis_xcvr_param #(
    parameter int DATA_W   = 24,
    parameter int SLOT_W   = 32,
    parameter int BCLK_DIV = 16,
    parameter int MODE     = 0
) (
    input  logic              clk_100m,
    input  logic              rst,
    output logic              bclk,
    output logic              lrclk,
    output logic              sdata_o,
    input  logic              sdata_i,
    input  logic [DATA_W-1:0] tx_ldata,
    input  logic [DATA_W-1:0] tx_rdata,
    input  logic              tx_valid,
    output logic              tx_ready,
    output logic              tx_underrun,
    output logic [DATA_W-1:0] rx_ldata,
    output logic [DATA_W-1:0] rx_rdata,
    output logic              rx_valid
);
    localparam int DW = $clog2(BCLK_DIV);
    localparam int CW = $clog2(2 * SLOT_W);
    localparam int D  = (MODE == 0) ? 1 : 0;

    logic [DW-1:0]     div_q, div_d;
    logic [CW-1:0]     bit_q, bit_d;
    logic              lrclk_q, lrclk_d, sdata_q, sdata_d, full_q, full_d;
    logic              und_q, und_d, rxv_q, rxv_d, seen_q, seen_d;
    logic [DATA_W-1:0] hold_l_q, hold_l_d, hold_r_q, hold_r_d, tx_l_q, tx_l_d, tx_r_q, tx_r_d;
    logic [DATA_W-1:0] cap_l_q, cap_l_d, cap_r_q, cap_r_d, rx_l_q, rx_l_d, rx_r_q, rx_r_d;
    logic [DATA_W-1:0] tx_sel, mask;
    logic              fall, rise, frame, hs, ch_tx, ch_rx, wr;
    int                p_tx, p_rx;

    // Sample bit index carried by frame bit b, or -1 outside the data window.
    function automatic int pos(input logic [CW-1:0] b);
        int k;
        k = int'(b) - ((int'(b) >= SLOT_W) ? SLOT_W : 0);
        return (k >= D && k < D + DATA_W) ? DATA_W - 1 - (k - D) : -1;
    endfunction

    always_comb begin
        fall     = div_q == DW'(BCLK_DIV - 1);
        rise     = div_q == DW'(BCLK_DIV / 2 - 1);
        frame    = fall && bit_q == CW'(2 * SLOT_W - 1);
        div_d    = fall ? '0 : div_q + 1'b1;
        bit_d    = fall ? (frame ? '0 : bit_q + 1'b1) : bit_q;
        lrclk_d  = fall ? (int'(bit_d) >= SLOT_W) : lrclk_q;
        hs       = tx_valid && tx_ready;
        full_d   = hs || (full_q && !frame);
        hold_l_d = hs ? tx_ldata : hold_l_q;
        hold_r_d = hs ? tx_rdata : hold_r_q;
        tx_l_d   = frame ? (full_q ? hold_l_q : '0) : tx_l_q;
        tx_r_d   = frame ? (full_q ? hold_r_q : '0) : tx_r_q;
        und_d    = frame && !full_q;
        // The bit driven at a FALL belongs to the bit slot being entered.
        p_tx     = pos(bit_d);
        ch_tx    = int'(bit_d) >= SLOT_W;
        tx_sel   = (ch_tx ? tx_r_d : tx_l_d) >> p_tx;
        sdata_d  = fall ? (p_tx >= 0 && tx_sel[0]) : sdata_q;
        p_rx     = pos(bit_q);
        ch_rx    = int'(bit_q) >= SLOT_W;
        wr       = rise && p_rx >= 0;
        mask     = DATA_W'(1) << p_rx;
        cap_l_d  = (wr && !ch_rx) ? (sdata_i ? cap_l_q | mask : cap_l_q & ~mask) : cap_l_q;
        cap_r_d  = (wr && ch_rx) ? (sdata_i ? cap_r_q | mask : cap_r_q & ~mask) : cap_r_q;
        rx_l_d   = frame ? cap_l_q : rx_l_q;
        rx_r_d   = frame ? cap_r_q : rx_r_q;
        rxv_d    = frame && seen_q;
        seen_d   = seen_q || frame;
    end

    always_ff @(posedge clk_100m) begin
        if (rst) begin
            div_q    <= '0;
            bit_q    <= CW'(2 * SLOT_W - 1);
            lrclk_q  <= 1'b0;
            sdata_q  <= 1'b0;
            full_q   <= 1'b0;
            und_q    <= 1'b0;
            rxv_q    <= 1'b0;
            seen_q   <= 1'b0;
            hold_l_q <= '0;
            hold_r_q <= '0;
            tx_l_q   <= '0;
            tx_r_q   <= '0;
            cap_l_q  <= '0;
            cap_r_q  <= '0;
            rx_l_q   <= '0;
            rx_r_q   <= '0;
        end else begin
            div_q    <= div_d;
            bit_q    <= bit_d;
            lrclk_q  <= lrclk_d;
            sdata_q  <= sdata_d;
            full_q   <= full_d;
            und_q    <= und_d;
            rxv_q    <= rxv_d;
            seen_q   <= seen_d;
            hold_l_q <= hold_l_d;
            hold_r_q <= hold_r_d;
            tx_l_q   <= tx_l_d;
            tx_r_q   <= tx_r_d;
            cap_l_q  <= cap_l_d;
            cap_r_q  <= cap_r_d;
            rx_l_q   <= rx_l_d;
            rx_r_q   <= rx_r_d;
        end
    end

    assign bclk        = div_q >= DW'(BCLK_DIV / 2);
    assign lrclk       = lrclk_q;
    assign sdata_o     = sdata_q;
    assign tx_ready    = !rst && !full_q;
    assign tx_underrun = und_q;
    assign rx_ldata    = rx_l_q;
    assign rx_rdata    = rx_r_q;
    assign rx_valid    = rxv_q;
endmodule

// File: tb/tb_iis_xcvr_param.sv
// tb_iis_xcvr_param: I2S (u0) and left-justified (u1) instances in loopback, checked
// against a frame-level model and an RX pair scoreboard.
module tb_iis_xcvr_param;
    logic        clk = 1'b0, rst = 1'b1, tx_valid = 1'b0;
    logic [23:0] tx_l = '0, tx_r = '0;
    logic        bclk_w[2], lr_w[2], sd_w[2], rdy_w[2], und_w[2], rxv_w[2];
    logic [23:0] rxl_w[2], rxr_w[2];
    int          n = 0, f = -1, fc = 0, n_chk = 0, n_fail = 0;
    logic [47:0] cur = '0;
    logic        e_und = 1'b0, e_rxv = 1'b0;
    logic [47:0] hold[$], q0[$], q1[$];

    always #5 clk = ~clk;

    iis_xcvr_param #(.DATA_W(24), .SLOT_W(32), .BCLK_DIV(4), .MODE(0)) u0 (
        .clk_100m(clk), .rst(rst), .bclk(bclk_w[0]), .lrclk(lr_w[0]), .sdata_o(sd_w[0]),
        .sdata_i(sd_w[0]), .tx_ldata(tx_l), .tx_rdata(tx_r), .tx_valid(tx_valid),
        .tx_ready(rdy_w[0]), .tx_underrun(und_w[0]), .rx_ldata(rxl_w[0]), .rx_rdata(rxr_w[0]),
        .rx_valid(rxv_w[0]));
    iis_xcvr_param #(.DATA_W(24), .SLOT_W(32), .BCLK_DIV(4), .MODE(1)) u1 (
        .clk_100m(clk), .rst(rst), .bclk(bclk_w[1]), .lrclk(lr_w[1]), .sdata_o(sd_w[1]),
        .sdata_i(sd_w[1]), .tx_ldata(tx_l), .tx_rdata(tx_r), .tx_valid(tx_valid),
        .tx_ready(rdy_w[1]), .tx_underrun(und_w[1]), .rx_ldata(rxl_w[1]), .rx_rdata(rxr_w[1]),
        .rx_valid(rxv_w[1]));

    task automatic chk(input string nm, input int i, input logic [47:0] a, input logic [47:0] e);
        n_chk++;
        if (a !== e) begin
            n_fail++;
            $display("FAIL %s[%0d] got %h want %h at %0t", nm, i, a, e, $time);
        end
    endtask

    // Frame bit f%64: 32-bit slots, 24-bit MSB-first window starting at slot bit d.
    function automatic logic exp_sd(input int i);
        int b, k, d;
        logic [23:0] w;
        if (f < 0) return 1'b0;
        b = f % 64;
        k = b % 32;
        d = (i == 0) ? 1 : 0;
        w = (b >= 32) ? cur[23:0] : cur[47:24];
        if (k < d || k >= d + 24) return 1'b0;
        w = w >> (23 - (k - d));
        return w[0];
    endfunction

    // n: index of the next clk edge since reset release; edge n%4==3 is a bclk fall.
    always @(posedge clk) begin
        logic hs;
        if (rst) begin
            n = 0; f = -1; fc = 0; cur = '0; e_und = 1'b0; e_rxv = 1'b0;
            hold.delete(); q0.delete(); q1.delete();
        end else begin
            hs = tx_valid && hold.size() == 0;
            e_und = 1'b0;
            e_rxv = 1'b0;
            if (n % 4 == 3) f++;
            if (n % 256 == 3) begin
                e_rxv = fc >= 1;
                fc++;
                e_und = hold.size() == 0;
                cur = e_und ? 48'h0 : hold.pop_front();
                q0.push_back(cur);
                q1.push_back(cur);
            end
            if (hs) hold.push_back({tx_l, tx_r});
            n++;
        end
    end

    always @(posedge clk) begin
        logic [47:0] e;
        #1;
        for (int i = 0; i < 2; i++) begin
            chk("bclk", i, 48'(bclk_w[i]), 48'((n % 4) >= 2));
            chk("lrclk", i, 48'(lr_w[i]), 48'(f >= 0 && (f % 64) >= 32));
            chk("sdata_o", i, 48'(sd_w[i]), 48'(exp_sd(i)));
            chk("tx_ready", i, 48'(rdy_w[i]), 48'(!rst && hold.size() == 0));
            chk("tx_underrun", i, 48'(und_w[i]), 48'(e_und));
            chk("rx_valid", i, 48'(rxv_w[i]), 48'(e_rxv));
            if (rxv_w[i] === 1'b1) begin
                if ((i == 0 && q0.size() == 0) || (i == 1 && q1.size() == 0)) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL rx_pair[%0d] got rx_valid want no pair pending", i);
                end else begin
                    if (i == 0) e = q0.pop_front();
                    else e = q1.pop_front();
                    chk("rx_pair", i, {rxl_w[i], rxr_w[i]}, e);
                end
            end
        end
    end

    task automatic rnd(input int cyc, input int pct);
        repeat (cyc) begin
            @(negedge clk);
            tx_valid = int'($urandom_range(0, 99)) < pct;
            tx_l = 24'($urandom);
            tx_r = 24'($urandom);
        end
    endtask

    initial begin
        int t;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        tx_l = 24'hA5A5A5;
        tx_r = 24'h5A5A5A;
        tx_valid = 1'b1;
        @(negedge clk);
        tx_valid = 1'b0;
        repeat (600) @(negedge clk);
        rnd(40 * 256, 3);
        tx_valid = 1'b0;
        repeat (3 * 256) @(negedge clk);
        t = 0;
        while (n % 256 != 3 && t < 300) begin
            @(negedge clk);
            t++;
        end
        if (t >= 300) begin
            n_chk++; n_fail++;
            $display("FAIL frame_wait got timeout want frame cycle");
        end
        tx_valid = 1'b1;
        tx_l = 24'($urandom);
        tx_r = 24'($urandom);
        @(negedge clk);
        tx_valid = 1'b0;
        repeat (600) @(negedge clk);
        rnd(2 * 256, 5);
        tx_valid = 1'b1;
        t = 0;
        while (!(f >= 0 && f % 64 == 40) && t < 300) begin
            @(negedge clk);
            t++;
        end
        if (t >= 300) begin
            n_chk++; n_fail++;
            $display("FAIL bit40_wait got timeout want bit 40");
        end
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        tx_valid = 1'b0;
        rnd(6 * 256, 4);
        tx_valid = 1'b0;
        repeat (600) @(negedge clk);
        chk("pending", 0, 48'(q0.size() <= 1), 48'(1));
        chk("pending", 1, 48'(q1.size() <= 1), 48'(1));
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
